// File: rtl/led_matrix_scroller.sv
// led_matrix_scroller: row-scan LED matrix driver with glyph step/scroll, per-row PWM,
// anti-ghost blanking and content updates applied only at frame boundaries.
module led_matrix_scroller #(
  parameter int N_ROWS      = 8,
  parameter int N_COLS      = 8,
  parameter int N_GLYPHS    = 5,
  parameter int ROW_DWELL   = 256,
  parameter bit MIRROR_COLS = 1,
  parameter bit FLIP_ROWS   = 0
) (
  input  logic                        clk500khz,
  input  logic                        reset_n,
  input  logic                        run,
  input  logic                        frame_tick,
  input  logic                        mode,
  input  logic [3:0]                  bright,
  output logic [$clog2(N_GLYPHS)-1:0] glyph_idx_a,
  output logic [$clog2(N_GLYPHS)-1:0] glyph_idx_b,
  output logic [$clog2(N_ROWS)-1:0]   glyph_row,
  input  logic [N_COLS-1:0]           glyph_bits_a,
  input  logic [N_COLS-1:0]           glyph_bits_b,
  output logic [N_ROWS-1:0]           row_n,
  output logic [N_COLS-1:0]           col,
  output logic                        frame_start
);
  localparam int DW  = $clog2(ROW_DWELL);
  localparam int RW  = $clog2(N_ROWS);
  localparam int GW  = $clog2(N_GLYPHS);
  localparam int TOT = N_GLYPHS * N_COLS;
  localparam int PW  = $clog2(TOT);
  localparam int SW  = $clog2(N_COLS);

  logic [DW-1:0]     r_dwell;
  logic [RW-1:0]     r_row;
  logic [PW-1:0]     r_pos;
  logic              r_pend;
  logic              r_mode;
  logic [3:0]        r_bright;
  logic              w_row_end;
  logic              w_bound;
  logic              w_lit;
  logic [RW-1:0]     w_row_eff;
  logic [PW:0]       w_pos_sum;
  logic [PW-1:0]     w_pos_nxt;
  logic [SW-1:0]     w_sub;
  logic [DW-1:0]     w_thr;
  logic [N_COLS-1:0] w_win;
  logic [N_COLS-1:0] w_col;

  always_comb begin
    w_row_end   = r_dwell == DW'(ROW_DWELL - 1);
    w_bound     = w_row_end && r_row == RW'(N_ROWS - 1);
    w_row_eff   = FLIP_ROWS ? RW'(N_ROWS - 1) - r_row : r_row;
    w_pos_sum   = {1'b0, r_pos} + (r_mode ? (PW+1)'(1) : (PW+1)'(N_COLS));
    w_pos_nxt   = w_pos_sum >= (PW+1)'(TOT) ? PW'(w_pos_sum - (PW+1)'(TOT)) : PW'(w_pos_sum);
    glyph_idx_a = GW'(r_pos / PW'(N_COLS));
    glyph_idx_b = glyph_idx_a == GW'(N_GLYPHS - 1) ? '0 : glyph_idx_a + 1'b1;
    glyph_row   = w_row_eff;
    w_sub       = SW'(r_pos % PW'(N_COLS));
    // Left glyph's tail followed by the right glyph's head, sub columns in.
    w_win       = N_COLS'(({glyph_bits_a, glyph_bits_b} << w_sub) >> N_COLS);
    w_thr       = DW'(r_bright * (ROW_DWELL / 16));
    w_lit       = r_dwell != '0 && r_dwell <= w_thr;
  end

  for (genvar i = 0; i < N_COLS; i++) begin : g_mirror
    assign w_col[i] = MIRROR_COLS ? w_win[N_COLS-1-i] : w_win[i];
  end

  always_ff @(posedge clk500khz or negedge reset_n) begin
    if (!reset_n) begin
      r_dwell     <= '0;
      r_row       <= '0;
      r_pos       <= '0;
      r_pend      <= 1'b0;
      r_mode      <= 1'b0;
      r_bright    <= '0;
      row_n       <= '1;
      col         <= '0;
      frame_start <= 1'b0;
    end else begin
      r_dwell <= w_row_end ? '0 : r_dwell + 1'b1;
      if (w_row_end)
        r_row <= r_row == RW'(N_ROWS - 1) ? '0 : r_row + 1'b1;
      if (r_dwell == '0)
        r_bright <= bright;
      // A tick landing in the boundary cycle carries over to the next frame.
      if (w_bound) begin
        r_mode <= mode;
        r_pend <= run & frame_tick;
        if (mode != r_mode)
          r_pos <= '0;
        else if (r_pend)
          r_pos <= w_pos_nxt;
      end else begin
        r_pend <= run & (r_pend | frame_tick);
      end
      row_n       <= w_lit ? ~(N_ROWS'(1) << w_row_eff) : '1;
      col         <= w_lit ? w_col : '0;
      frame_start <= r_row == '0 && r_dwell == '0;
    end
  end
endmodule

// File: tb/tb_led_matrix_scroller.sv
// tb_led_matrix_scroller: randomized scoreboard bench; two instances (plain and flipped/unmirrored)
// are checked every cycle against a string-level reference model.
`timescale 1ns/1ps
module tb_led_matrix_scroller;
  localparam int NR  = 4;
  localparam int NC  = 8;
  localparam int NG  = 5;
  localparam int RD  = 32;
  localparam int TOT = NG * NC;
  localparam int FR  = NR * RD;
  localparam int GW  = $clog2(NG);
  localparam int RW  = $clog2(NR);

  logic clk = 0, reset_n = 0, run = 0, frame_tick = 0, mode = 0;
  logic [3:0] bright = 0;
  logic [GW-1:0] ga0, gb0, ga1, gb1;
  logic [RW-1:0] gr0, gr1;
  logic [NC-1:0] ba0, bb0, ba1, bb1, col0, col1;
  logic [NR-1:0] rn0, rn1;
  logic fs0, fs1;
  logic [NC-1:0] rom [NG][NR];

  assign ba0 = rom[ga0][gr0];
  assign bb0 = rom[gb0][gr0];
  assign ba1 = rom[ga1][gr1];
  assign bb1 = rom[gb1][gr1];

  always #1000 clk = ~clk;

  led_matrix_scroller #(.N_ROWS(NR), .N_COLS(NC), .N_GLYPHS(NG), .ROW_DWELL(RD),
                        .MIRROR_COLS(1), .FLIP_ROWS(0)) u0 (
    .clk500khz(clk), .reset_n(reset_n), .run(run), .frame_tick(frame_tick), .mode(mode),
    .bright(bright), .glyph_idx_a(ga0), .glyph_idx_b(gb0), .glyph_row(gr0),
    .glyph_bits_a(ba0), .glyph_bits_b(bb0), .row_n(rn0), .col(col0), .frame_start(fs0));

  led_matrix_scroller #(.N_ROWS(NR), .N_COLS(NC), .N_GLYPHS(NG), .ROW_DWELL(RD),
                        .MIRROR_COLS(0), .FLIP_ROWS(1)) u1 (
    .clk500khz(clk), .reset_n(reset_n), .run(run), .frame_tick(frame_tick), .mode(mode),
    .bright(bright), .glyph_idx_a(ga1), .glyph_idx_b(gb1), .glyph_row(gr1),
    .glyph_bits_a(ba1), .glyph_bits_b(bb1), .row_n(rn1), .col(col1), .frame_start(fs1));

  typedef struct {
    int cyc;
    logic [NR-1:0] rn0, rn1;
    logic [NC-1:0] c0, c1;
    logic fs;
  } exp_t;

  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  int m_t, m_pos, m_b;
  bit m_pend, m_mode;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Column c of the visible window is column pos+c of the endless glyph string.
  function automatic logic [NC-1:0] model_col(input int p, input int re, input bit mir);
    logic [NC-1:0] v;
    int s;
    v = '0;
    for (int c = 0; c < NC; c++) begin
      s = p + c;
      if (mir) v[c] = rom[(s / NC) % NG][re][NC-1-(s % NC)];
      else     v[NC-1-c] = rom[(s / NC) % NG][re][NC-1-(s % NC)];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_t = 0; m_pos = 0; m_b = 0; m_pend = 0; m_mode = 0;
  endtask

  task automatic step();
    int dw, row;
    bit lit;
    exp_t e;
    dw  = m_t % RD;
    row = (m_t / RD) % NR;
    lit = dw != 0 && dw <= m_b * RD / 16;
    e.cyc = cyc + 1;
    e.rn0 = lit ? ~(NR'(1) << row) : '1;
    e.rn1 = lit ? ~(NR'(1) << (NR - 1 - row)) : '1;
    e.c0  = lit ? model_col(m_pos, row, 1'b1) : '0;
    e.c1  = lit ? model_col(m_pos, NR - 1 - row, 1'b0) : '0;
    e.fs  = m_t % FR == 0;
    q.push_back(e);
    if (dw == 0) m_b = int'(bright);
    if (row == NR - 1 && dw == RD - 1) begin
      if (mode != m_mode) m_pos = 0;
      else if (m_pend) m_pos = (m_pos + (m_mode ? 1 : NC)) % TOT;
      m_mode = mode;
      m_pend = run && frame_tick;
    end else begin
      m_pend = run ? (m_pend || frame_tick) : 1'b0;
    end
    m_t++;
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n, input int tick_div, input int brt_div, input int run_div, input int mode_div);
    for (int i = 0; i < n; i++) begin
      frame_tick = tick_div > 0 && $urandom_range(0, tick_div - 1) == 0;
      if (brt_div > 0 && $urandom_range(0, brt_div - 1) == 0) bright = 4'($urandom_range(0, 15));
      if (run_div > 0 && $urandom_range(0, run_div - 1) == 0) run = ~run;
      if (mode_div > 0 && $urandom_range(0, mode_div - 1) == 0) mode = ~mode;
      step();
    end
    frame_tick = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_n0"}, 32'(rn0), 32'(NR'('1)));
    check({tag, "_col0"}, 32'(col0), 32'h0);
    check({tag, "_fs0"}, 32'(fs0), 32'h0);
    check({tag, "_row_n1"}, 32'(rn1), 32'(NR'('1)));
    check({tag, "_col1"}, 32'(col1), 32'h0);
    check({tag, "_fs1"}, 32'(fs1), 32'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("stale_expectation", 32'(e.cyc), 32'(cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("row_n_u0", 32'(rn0), 32'(e.rn0));
      check("col_u0", 32'(col0), 32'(e.c0));
      check("frame_start_u0", 32'(fs0), 32'(e.fs));
      check("row_n_u1", 32'(rn1), 32'(e.rn1));
      check("col_u1", 32'(col1), 32'(e.c1));
      check("frame_start_u1", 32'(fs1), 32'(e.fs));
    end
  end

  initial begin
    int k;
    for (int g = 0; g < NG; g++)
      for (int r = 0; r < NR; r++)
        rom[g][r] = NC'($urandom);
    rom[0][0] = 8'hF0;
    rom[1][0] = 8'h0F;
    bright = 15; run = 1; mode = 0;
    #2500;
    check_reset_outputs("in_reset");
    @(negedge clk);
    reset_n = 1;
    model_reset();
    cycles(3 * FR, 0, 0, 0, 0);
    cycles(12 * FR, 40, 60, 0, 0);
    mode = 1;
    bright = 15;
    cycles(60 * FR, 8, 200, 0, 0);
    cycles(20 * FR, 20, 30, 50, 600);
    run = 1;
    bright = 0;
    cycles(2 * FR, 10, 0, 0, 0);
    bright = 8;
    cycles(2 * FR, 10, 0, 0, 0);
    bright = 15;
    k = (RD + RD / 2 - m_t % RD) % RD + RD;
    cycles(k, 0, 0, 0, 0);
    @(negedge clk);
    #200;
    reset_n = 0;
    #1;
    check_reset_outputs("mid_row_reset");
    q.delete();
    @(negedge clk);
    reset_n = 1;
    model_reset();
    cycles(3 * FR, 10, 40, 0, 0);
    @(negedge clk);
    #10;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_matrix_scroller.md
# led_matrix_scroller

Parametrised row-scan controller for an N_ROWS x N_COLS LED matrix. Adds four things on top of the fixed 8x8 hello-frame scanner:
- glyph stepping or column-by-column scrolling over a glyph string,
- per-row PWM brightness,
- anti-ghost row blanking,
- tear-free content updates applied only at frame boundaries.

It runs entirely in the 500 kHz scan domain, sits between the clock divider and the board pins, and reads glyph rows from an external combinational ROM.

## Interface
- N_ROWS, 8, matrix rows (≥2)
- N_COLS, 8, matrix columns (≥2)
- N_GLYPHS, 5, glyphs in the string (≥2)
- ROW_DWELL, 256, clk500khz cycles per row; multiple of 16, ≥32
- MIRROR_COLS, 1, reverse col bit order at output
- FLIP_ROWS, 0, scan rows in reverse physical order

Ports:
- clk500khz  in  1  scan clock
- reset_n  in  1  reset, asynchronous, active-low
- run  in  1  enables content advance; scanning always runs
- frame_tick  in  1  single-cycle advance request, synchronous to clk500khz
- mode  in  1  0 = step (one glyph per advance), 1 = scroll (one column per advance)
- bright  in  4  brightness 0..15
- glyph_idx_a  out  clog2(N_GLYPHS)  left glyph address
- glyph_idx_b  out  clog2(N_GLYPHS)  right glyph address
- glyph_row  out  clog2(N_ROWS)  effective row address to ROM
- glyph_bits_a  in  N_COLS  ROM row for glyph_idx_a; bit N_COLS-1 is the leftmost column
- glyph_bits_b  in  N_COLS  ROM row for glyph_idx_b
- row_n  out  N_ROWS  active-low one-hot row drive
- col  out  N_COLS  active-high column drive
- frame_start  out  1  one-cycle pulse, aligned with the blank cycle of row 0

## Operation
Counters and addressing:
- dwell_cnt counts 0..ROW_DWELL-1. At ROW_DWELL-1 it wraps, and row_idx increments and wraps from N_ROWS-1 to 0.
- Frame boundary: row_idx = N_ROWS-1 and dwell_cnt = ROW_DWELL-1.
- row_eff = FLIP_ROWS ? N_ROWS-1-row_idx : row_idx. glyph_row = row_eff.
- pos is a width clog2(N_GLYPHS*N_COLS) counter over 0..N_GLYPHS*N_COLS-1.
- glyph_idx_a = pos / N_COLS; sub = pos % N_COLS; glyph_idx_b = (glyph_idx_a+1) mod N_GLYPHS.
- Window = upper N_COLS bits of ({glyph_bits_a, glyph_bits_b} << sub), computed at 2*N_COLS width.
- Output columns are the window, bit-reversed when MIRROR_COLS = 1.

Advance:
- frame_tick with run = 1 sets pending. Multiple ticks before the boundary collapse into one advance.
- run = 0 clears pending and ignores ticks.
- At the frame boundary:
  - mode is latched.
  - If the latched mode changed, pos <= 0 and pending is cleared.
  - Otherwise, if pending: pos += N_COLS (step) or pos += 1 (scroll), modulo N_GLYPHS*N_COLS, and pending is cleared.
- Step mode therefore keeps sub = 0.

Brightness:
- bright is latched when dwell_cnt = 0. Call the latched value b.
- The row is lit when 1 ≤ dwell_cnt ≤ b*ROW_DWELL/16.
- b = 0 means dark. b = 15 means 15/16 on-time, minus the blank cycle.

## Timing
Reset values:
- row_n all ones, col 0, frame_start 0.
- dwell_cnt 0, row_idx 0, pos 0, pending 0, latched mode 0, latched bright 0.

Output pipeline:
- row_n and col are registered. They reflect the state of the previous cycle: 1-cycle latency from dwell_cnt/row_idx.
- dwell_cnt = 0 cycle: registers load row_n all ones and col 0. This is the blank cycle, which gives one blank cycle per row.
- Lit cycle: row_n = ~(1 << row_eff) and col = window.
- Unlit cycle: row_n all ones and col 0.

ROM and address timing:
- The ROM is combinational. glyph_bits are sampled in the same cycle the addresses are presented.
- Addresses derive only from registered row_idx/pos, so they never change mid-dwell except at a row switch.

Frame timing:
- frame_start is registered; high in the output cycle that follows row_idx = 0, dwell_cnt = 0.
- Frame period: N_ROWS*ROW_DWELL cycles; 2048 with the defaults (≈244 Hz).

Boundary conditions:
- A pos update at the boundary is visible from the next frame's row 0 onward. No frame ever mixes two pos values.
- frame_tick in the boundary cycle itself is registered as pending for the following boundary.
- reset_n asserted mid-frame forces all outputs to their reset values asynchronously. Scanning restarts at row 0, pos 0.

## Test plan
- Reset, then bright=15: row_n=8'hFF and col=0 during reset and in cycle 1. From cycle 2, row_n=8'hFE. frame_start pulses every 2048 cycles.
- Step mode, ROM stub returns glyph index in all bits; tick at mid-frame: glyph_idx_a changes 0→1 only at the next frame boundary. Three ticks in one frame still produce one advance.
- Scroll mode: set pos=3 via 3 ticks over 3 frames, with bits_a=8'hF0 and bits_b=8'h0F. Window = 8'h80; col = 8'h01 with MIRROR_COLS=1.
- Wrap: scroll from pos=39 (N_GLYPHS=5, N_COLS=8). Next pos=0. At pos=32, glyph_idx_a=4 and glyph_idx_b=0.
- Brightness: bright=0 keeps col=0 for all rows. bright=8 keeps each row lit exactly 128 cycles, and row_n=8'hFF in the blank cycle. Changing bright mid-row has no effect until the next row.
- run=0 ignores ticks and pos holds. Toggling mode clears pos to 0 at the boundary. Asserting reset_n mid-row gives row_n=8'hFF and col=0 immediately.
